// File: rtl/pkt_merger.sv
// rtl/pkt_merger.sv - round-robin merge of NUM_CHANNELS valid/ready packet streams into one
module pkt_merger #(
  parameter int PACKET_BITS  = 72,
  parameter int NUM_CHANNELS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PACKET_BITS-1:0] pkt_in_data_in [NUM_CHANNELS],
  input  logic                   pkt_in_vld_in  [NUM_CHANNELS],
  output logic                   pkt_in_rdy_out [NUM_CHANNELS],
  output logic [PACKET_BITS-1:0] pkt_out_data_out,
  output logic                   pkt_out_vld_out,
  input  logic                   pkt_out_rdy_in,
  output logic [3:0]             last_grant_out
);

  logic                   full;
  logic [PACKET_BITS-1:0] data_q;
  logic [3:0]             last_grant;

  logic                   any_vld;
  logic [3:0]             grant;
  logic                   load;
  logic [PACKET_BITS-1:0] grant_data;

  // Two descending passes: the first finds the lowest valid channel at or below
  // last_grant (the wrap-around candidate), the second overrides it with the
  // lowest valid channel above last_grant, which is where the rotation resumes.
  always_comb begin
    any_vld = 1'b0;
    grant   = '0;
    for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
      if (pkt_in_vld_in[c] && (c <= int'(last_grant))) begin
        grant   = 4'(c);
        any_vld = 1'b1;
      end
    end
    for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
      if (pkt_in_vld_in[c] && (c > int'(last_grant))) begin
        grant   = 4'(c);
        any_vld = 1'b1;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (grant == 4'(c)) begin
        grant_data = pkt_in_data_in[c];
      end
    end
  end

  // The output slot frees up in the same cycle it is drained, so a full
  // register with a ready consumer still accepts a new packet.
  assign load = any_vld && (!full || pkt_out_rdy_in) && !reset;

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      pkt_in_rdy_out[c] = load && (grant == 4'(c));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full       <= 1'b0;
      data_q     <= '0;
      last_grant <= 4'(NUM_CHANNELS - 1);
    end else if (load) begin
      full       <= 1'b1;
      data_q     <= grant_data;
      last_grant <= grant;
    end else if (pkt_out_rdy_in) begin
      full       <= 1'b0;
    end
  end

  assign pkt_out_data_out = data_q;
  assign pkt_out_vld_out  = full;
  assign last_grant_out   = last_grant;

endmodule

// File: tb/tb_pkt_merger.sv
// tb/tb_pkt_merger.sv - vector table, corner sequences and random scoreboard for pkt_merger
module tb_pkt_merger;
  localparam int PB = 72;
  localparam int NC = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [PB-1:0] in_data [NC];
  logic          in_vld  [NC];
  logic          in_rdy  [NC];
  logic [PB-1:0] out_data;
  logic          out_vld;
  logic          out_rdy;
  logic [3:0]    last_grant;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pkt_merger #(.PACKET_BITS(PB), .NUM_CHANNELS(NC)) dut (
    .clk              (clk),
    .reset            (reset),
    .pkt_in_data_in   (in_data),
    .pkt_in_vld_in    (in_vld),
    .pkt_in_rdy_out   (in_rdy),
    .pkt_out_data_out (out_data),
    .pkt_out_vld_out  (out_vld),
    .pkt_out_rdy_in   (out_rdy),
    .last_grant_out   (last_grant)
  );

  typedef struct {
    logic [NC-1:0] vld;
    logic          ordy;
    logic [NC-1:0] exp_rdy;
    logic          exp_vld;
    int            exp_ch;
    logic [3:0]    exp_last;
  } vec_t;

  vec_t tbl [15];

  function automatic logic [PB-1:0] chan_data(input int c);
    return {64'h0123_4567_89AB_CDEF, 8'hA0 + 8'(c)};
  endfunction

  function automatic logic [NC-1:0] rdy_vec();
    logic [NC-1:0] v;
    for (int c = 0; c < NC; c++) v[c] = in_rdy[c];
    return v;
  endfunction

  task automatic check(input string name, input logic [PB-1:0] act, input logic [PB-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_vld(input logic [NC-1:0] v);
    for (int c = 0; c < NC; c++) in_vld[c] = v[c];
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    out_rdy = 1'b0;
    set_vld('0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  logic [NC-1:0] r_vld;
  logic [PB-1:0] r_data [NC];
  int            sent [NC];
  int            recv [NC];
  int            starve [NC];
  logic          m_full;
  logic [PB-1:0] m_data;
  int            m_last;
  int            g, ch, pkts_out, total_sent, cycles;
  logic          ordy, mload;
  logic [NC-1:0] er;

  initial begin
    tbl = '{
      '{8'h89, 1'b1, 8'h01, 1'b1, 0, 4'd0},
      '{8'h88, 1'b1, 8'h08, 1'b1, 3, 4'd3},
      '{8'h80, 1'b1, 8'h80, 1'b1, 7, 4'd7},
      '{8'h00, 1'b1, 8'h00, 1'b0, 7, 4'd7},
      '{8'h24, 1'b0, 8'h04, 1'b1, 2, 4'd2},
      '{8'h24, 1'b0, 8'h00, 1'b1, 2, 4'd2},
      '{8'h24, 1'b1, 8'h20, 1'b1, 5, 4'd5},
      '{8'h24, 1'b1, 8'h04, 1'b1, 2, 4'd2},
      '{8'h20, 1'b1, 8'h20, 1'b1, 5, 4'd5},
      '{8'h20, 1'b1, 8'h20, 1'b1, 5, 4'd5},
      '{8'h00, 1'b0, 8'h00, 1'b1, 5, 4'd5},
      '{8'h00, 1'b1, 8'h00, 1'b0, 5, 4'd5},
      '{8'h40, 1'b0, 8'h40, 1'b1, 6, 4'd6},
      '{8'hFF, 1'b1, 8'h80, 1'b1, 7, 4'd7},
      '{8'hFF, 1'b1, 8'h01, 1'b1, 0, 4'd0}
    };

    reset   = 1'b1;
    out_rdy = 1'b1;
    for (int c = 0; c < NC; c++) in_data[c] = chan_data(c);
    set_vld('1);
    @(posedge clk); #1;
    check("rst_rdy", PB'(rdy_vec()), '0);
    check("rst_vld", PB'(out_vld), '0);
    check("rst_data", out_data, '0);
    check("rst_last", PB'(last_grant), PB'(NC - 1));
    set_vld('0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      set_vld(tbl[i].vld);
      out_rdy = tbl[i].ordy;
      #1;
      check($sformatf("vec%0d_rdy", i), PB'(rdy_vec()), PB'(tbl[i].exp_rdy));
      @(posedge clk); #1;
      check($sformatf("vec%0d_vld", i), PB'(out_vld), PB'(tbl[i].exp_vld));
      check($sformatf("vec%0d_data", i), out_data, chan_data(tbl[i].exp_ch));
      check($sformatf("vec%0d_last", i), PB'(last_grant), PB'(tbl[i].exp_last));
    end

    // all channels valid: strict rotation, one packet per cycle
    do_reset();
    set_vld('1);
    out_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      check($sformatf("rr%0d_rdy", i), PB'(rdy_vec()), PB'(8'h01 << (i % NC)));
      @(posedge clk); #1;
      check($sformatf("rr%0d_vld", i), PB'(out_vld), PB'(1'b1));
      check($sformatf("rr%0d_data", i), out_data, chan_data(i % NC));
    end

    // single channel keeps winning
    do_reset();
    set_vld(8'h20);
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("solo%0d_rdy", i), PB'(rdy_vec()), PB'(8'h20));
      @(posedge clk); #1;
    end
    check("solo_last", PB'(last_grant), PB'(5));

    // backpressure holds output stable and blocks loads
    do_reset();
    set_vld(8'h04);
    out_rdy = 1'b1;
    @(posedge clk); #1;
    in_data[2] = {PB/8{8'h55}};
    out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp%0d_rdy2", i), PB'(in_rdy[2]), PB'(1'b0));
      @(posedge clk); #1;
      check($sformatf("bp%0d_vld", i), PB'(out_vld), PB'(1'b1));
      check($sformatf("bp%0d_data", i), out_data, chan_data(2));
    end
    out_rdy = 1'b1;
    #1;
    check("bp_release_rdy2", PB'(in_rdy[2]), PB'(1'b1));
    @(posedge clk); #1;
    check("bp_release_data", out_data, {PB/8{8'h55}});
    in_data[2] = chan_data(2);
    set_vld('0);

    // reset while full discards the packet and restarts rotation at channel 0
    do_reset();
    set_vld(8'h12);
    out_rdy = 1'b0;
    @(posedge clk); #1;
    check("rf_full", PB'(out_vld), PB'(1'b1));
    reset = 1'b1;
    out_rdy = 1'b1;
    #1;
    check("rf_rdy_in_reset", PB'(rdy_vec()), '0);
    @(posedge clk); #1;
    check("rf_vld", PB'(out_vld), '0);
    check("rf_data", out_data, '0);
    check("rf_last", PB'(last_grant), PB'(NC - 1));
    reset = 1'b0;
    #1;
    check("rf_first_rdy", PB'(rdy_vec()), PB'(8'h02));
    @(posedge clk); #1;
    check("rf_first_data", out_data, chan_data(1));
    #1;
    check("rf_second_rdy", PB'(rdy_vec()), PB'(8'h10));
    @(posedge clk); #1;
    check("rf_second_data", out_data, chan_data(4));
    set_vld('0);

    // random traffic against a behavioural model and per-channel scoreboard
    do_reset();
    r_vld = '0;
    for (int c = 0; c < NC; c++) begin
      r_data[c] = '0;
      sent[c]   = 0;
      recv[c]   = 0;
      starve[c] = 0;
    end
    m_full = 1'b0;
    m_data = '0;
    m_last = NC - 1;
    pkts_out = 0;
    total_sent = 0;
    cycles = 0;
    while (pkts_out < 10000 && cycles < 60000 && n_fail < 50) begin
      cycles++;
      check("rnd_vld", PB'(out_vld), PB'(m_full));
      if (m_full) check("rnd_data", out_data, m_data);
      check("rnd_last", PB'(last_grant), PB'(m_last));
      for (int c = 0; c < NC; c++) begin
        if (!r_vld[c] && total_sent < 10000 && $urandom_range(0, 3) == 0) begin
          r_data[c] = {4'(c), 32'(sent[c]), 36'($urandom)};
          sent[c]++;
          total_sent++;
          r_vld[c] = 1'b1;
        end
        in_vld[c]  = r_vld[c];
        in_data[c] = r_data[c];
      end
      ordy = ($urandom_range(0, 9) < 7);
      out_rdy = ordy;
      #1;
      g = -1;
      for (int k = 1; k <= NC; k++) begin
        if (g < 0 && r_vld[(m_last + k) % NC]) g = (m_last + k) % NC;
      end
      mload = (g >= 0) && (!m_full || ordy);
      er = '0;
      if (mload) er[g] = 1'b1;
      check("rnd_rdy", PB'(rdy_vec()), PB'(er));
      if (m_full && ordy) begin
        ch = int'(out_data[71:68]);
        if (ch < NC) begin
          check($sformatf("rnd_order_ch%0d", ch), PB'(out_data[67:36]), PB'(recv[ch]));
          recv[ch]++;
        end
        pkts_out++;
      end
      for (int c = 0; c < NC; c++) begin
        if (!r_vld[c] || (mload && c == g)) begin
          starve[c] = 0;
        end else if (mload) begin
          starve[c]++;
          check($sformatf("rnd_starve_ch%0d", c), PB'(starve[c] < NC), PB'(1'b1));
        end
      end
      if (mload) begin
        m_full = 1'b1;
        m_data = r_data[g];
        m_last = g;
        r_vld[g] = 1'b0;
      end else if (ordy) begin
        m_full = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("rnd_all_delivered", PB'(pkts_out), PB'(10000));
    for (int c = 0; c < NC; c++) begin
      check($sformatf("rnd_count_ch%0d", c), PB'(recv[c]), PB'(sent[c]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
